// File: rtl/bg_colour_scheduler.sv
// Background colour source: shadows register-side colour/mode updates, commits them
// on the rising edge of vertical blank and sequences the frame-counted blink.
module bg_colour_scheduler #(
  parameter int          BLINK_FRAMES = 30,
  parameter int          CNT_W        = 8,
  parameter logic [11:0] RESET_RGB    = 12'h000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [11:0] cfg_rgb,
  input  logic [11:0] cfg_alt_rgb,
  input  logic [1:0]  cfg_mode,
  output logic [11:0] rgb_out,
  output logic        frame_tick,
  output logic        pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam logic [1:0] MODE_SOLID = 2'b00;
  localparam logic [1:0] MODE_BLINK = 2'b01;
  localparam logic [1:0] MODE_BLANK = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             vblnk_d_q, vblnk_d_d;
  logic             frame_edge;

  logic [11:0]      sh_rgb_q, sh_rgb_d;
  logic [11:0]      sh_alt_q, sh_alt_d;
  logic [1:0]       sh_mode_q, sh_mode_d;

  logic [11:0]      act_rgb_q, act_rgb_d;
  logic [11:0]      act_alt_q, act_alt_d;
  logic [1:0]       act_mode_q, act_mode_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  logic [11:0]      rgb_q, rgb_d;
  logic             tick_q, tick_d;
  logic             ready_q, ready_d;
  logic             pend_q, pend_d;

  // Mode 11 falls through to the primary colour, same as solid.
  function automatic logic [11:0] sel_colour(input logic [11:0] prim,
                                             input logic [11:0] alt,
                                             input logic [1:0]  mode,
                                             input logic        phase);
    logic [11:0] c;
    c = prim;
    if (mode == MODE_BLANK)
      c = 12'h000;
    else if (mode == MODE_BLINK && phase)
      c = alt;
    return c;
  endfunction

  assign frame_edge = vblnk_in & ~vblnk_d_q;

  always_comb begin
    state_d    = state_q;
    vblnk_d_d  = vblnk_in;
    sh_rgb_d   = sh_rgb_q;
    sh_alt_d   = sh_alt_q;
    sh_mode_d  = sh_mode_q;
    act_rgb_d  = act_rgb_q;
    act_alt_d  = act_alt_q;
    act_mode_d = act_mode_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;

    if (state_q == IDLE) begin
      // A capture in an edge cycle is left for the next edge.
      if (cfg_valid) begin
        sh_rgb_d  = cfg_rgb;
        sh_alt_d  = cfg_alt_rgb;
        sh_mode_d = cfg_mode;
        state_d   = PEND;
      end
      if (frame_edge && act_mode_q == MODE_BLINK) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    end else if (frame_edge) begin
      act_rgb_d  = sh_rgb_q;
      act_alt_d  = sh_alt_q;
      act_mode_d = sh_mode_q;
      cnt_d      = '0;
      phase_d    = 1'b0;
      state_d    = IDLE;
    end

    rgb_d   = sel_colour(act_rgb_q, act_alt_q, act_mode_q, phase_q);
    tick_d  = frame_edge;
    ready_d = (state_d == IDLE);
    pend_d  = (state_d == PEND);
  end

  // Register stage: control, active state and the output colour.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= IDLE;
      vblnk_d_q  <= 1'b1;
      act_rgb_q  <= RESET_RGB;
      act_alt_q  <= 12'h000;
      act_mode_q <= MODE_SOLID;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      rgb_q      <= RESET_RGB;
      tick_q     <= 1'b0;
      ready_q    <= 1'b1;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblnk_d_q  <= vblnk_d_d;
      act_rgb_q  <= act_rgb_d;
      act_alt_q  <= act_alt_d;
      act_mode_q <= act_mode_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      rgb_q      <= rgb_d;
      tick_q     <= tick_d;
      ready_q    <= ready_d;
      pend_q     <= pend_d;
    end
  end

  // Shadow contents are only meaningful while PEND, so they carry no reset.
  always_ff @(posedge pclk) begin
    sh_rgb_q  <= sh_rgb_d;
    sh_alt_q  <= sh_alt_d;
    sh_mode_q <= sh_mode_d;
  end

  assign rgb_out    = rgb_q;
  assign frame_tick = tick_q;
  assign cfg_ready  = ready_q;
  assign pending    = pend_q;

endmodule

// File: tb/tb_bg_colour_scheduler.sv
// Bench for bg_colour_scheduler: directed vector table, hand-written corner
// sequences and a randomized run against a frame-level reference model.
module tb_bg_colour_scheduler;

  localparam int          BF    = 2;
  localparam logic [11:0] R_RGB = 12'h000;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [11:0] cfg_rgb = 12'h000;
  logic [11:0] cfg_alt_rgb = 12'h000;
  logic [1:0]  cfg_mode = 2'b00;
  logic [11:0] rgb_out;
  logic        frame_tick;
  logic        pending;

  int n_tests = 0;
  int n_fail  = 0;

  bg_colour_scheduler #(
    .BLINK_FRAMES(BF),
    .CNT_W(8),
    .RESET_RGB(R_RGB)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .vblnk_in(vblnk_in),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_rgb(cfg_rgb),
    .cfg_alt_rgb(cfg_alt_rgb),
    .cfg_mode(cfg_mode),
    .rgb_out(rgb_out),
    .frame_tick(frame_tick),
    .pending(pending)
  );

  always #5 pclk = ~pclk;

  // Reference model: frames_since_commit drives the blink phase arithmetically.
  logic        m_vd = 1'b1;
  logic        m_pend = 1'b0;
  logic [11:0] m_sh_rgb = 12'h000, m_sh_alt = 12'h000;
  logic [1:0]  m_sh_mode = 2'b00;
  logic [11:0] m_prim = R_RGB, m_alt = 12'h000;
  logic [1:0]  m_mode = 2'b00;
  int          m_n = 0;
  logic [11:0] m_rgb = R_RGB;
  logic        m_tick = 1'b0;

  function automatic logic [11:0] m_colour(input logic [11:0] p, input logic [11:0] a,
                                           input logic [1:0] md, input int n);
    if (md == 2'b10) return 12'h000;
    if (md == 2'b01 && ((n / BF) % 2) == 1) return a;
    return p;
  endfunction

  task automatic model_clock(input logic r, input logic v, input logic cv,
                             input logic [11:0] c, input logic [11:0] a, input logic [1:0] md);
    logic        e;
    logic [11:0] nxt;
    if (r) begin
      m_vd = 1'b1; m_pend = 1'b0; m_prim = R_RGB; m_alt = 12'h000; m_mode = 2'b00;
      m_n = 0; m_rgb = R_RGB; m_tick = 1'b0;
    end else begin
      e   = v & ~m_vd;
      nxt = m_colour(m_prim, m_alt, m_mode, m_n);
      if (m_pend) begin
        if (e) begin
          m_prim = m_sh_rgb; m_alt = m_sh_alt; m_mode = m_sh_mode; m_n = 0; m_pend = 1'b0;
        end
      end else begin
        if (e && m_mode == 2'b01) m_n = m_n + 1;
        if (cv) begin
          m_sh_rgb = c; m_sh_alt = a; m_sh_mode = md; m_pend = 1'b1;
        end
      end
      m_tick = e;
      m_vd   = v;
      m_rgb  = nxt;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic cv,
                      input logic [11:0] c, input logic [11:0] a, input logic [1:0] md);
    rst = r; vblnk_in = v; cfg_valid = cv; cfg_rgb = c; cfg_alt_rgb = a; cfg_mode = md;
    @(posedge pclk);
    model_clock(r, v, cv, c, a, md);
    @(negedge pclk);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_cyc(input logic v);
    step(1'b0, v, 1'b0, 12'h000, 12'h000, 2'b00);
  endtask

  task automatic frame();
    for (int i = 0; i < 3; i++) idle_cyc(1'b0);
    for (int i = 0; i < 4; i++) idle_cyc(1'b1);
  endtask

  typedef struct {
    logic        r, v, cv;
    logic [11:0] c, a;
    logic [1:0]  md;
    logic [11:0] e_rgb;
    logic        e_tick, e_rdy, e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic cv, input logic [11:0] c,
                              input logic [1:0] md, input logic [11:0] e_rgb,
                              input logic e_tick, input logic e_rdy, input logic e_pend);
    vec_t t;
    t.r = r; t.v = v; t.cv = cv; t.c = c; t.a = 12'h000; t.md = md;
    t.e_rgb = e_rgb; t.e_tick = e_tick; t.e_rdy = e_rdy; t.e_pend = e_pend;
    return t;
  endfunction

  initial begin
    logic [11:0] blink_exp [5];
    logic        rv, vv, cvv, hi;
    logic [11:0] rc, ra;
    logic [1:0]  rm;
    int          len;

    // Reset held with vblank high, then released with vblank still high.
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(1, 1, 0, 12'h000, 2'b00, 12'h000, 0, 1, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 0, 12'h000, 2'b00, 12'h000, 0, 1, 0));
    for (int i = 0; i < 3; i++)  vecs.push_back(mk(0, 0, 0, 12'h000, 2'b00, 12'h000, 0, 1, 0));
    // Mid-frame update to F00, committed at the next rise.
    vecs.push_back(mk(0, 0, 1, 12'hF00, 2'b00, 12'h000, 0, 0, 1));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0, 0, 0, 12'h000, 2'b00, 12'h000, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 12'h000, 2'b00, 12'h000, 1, 1, 0));
    for (int i = 0; i < 3; i++)  vecs.push_back(mk(0, 1, 0, 12'h000, 2'b00, 12'hF00, 0, 1, 0));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0, 0, 0, 12'h000, 2'b00, 12'hF00, 0, 1, 0));
    // Update offered in the edge cycle itself: waits a whole frame.
    vecs.push_back(mk(0, 1, 1, 12'h0F0, 2'b00, 12'hF00, 1, 0, 1));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0, 1, 0, 12'h000, 2'b00, 12'hF00, 0, 0, 1));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0, 0, 0, 12'h000, 2'b00, 12'hF00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 12'h000, 2'b00, 12'hF00, 1, 1, 0));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk(0, 1, 0, 12'h000, 2'b00, 12'h0F0, 0, 1, 0));

    @(negedge pclk);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].v, vecs[i].cv, vecs[i].c, vecs[i].a, vecs[i].md);
      chk($sformatf("vec%0d rgb_out", i), rgb_out, vecs[i].e_rgb);
      chk($sformatf("vec%0d frame_tick", i), {11'b0, frame_tick}, {11'b0, vecs[i].e_tick});
      chk($sformatf("vec%0d cfg_ready", i), {11'b0, cfg_ready}, {11'b0, vecs[i].e_rdy});
      chk($sformatf("vec%0d pending", i), {11'b0, pending}, {11'b0, vecs[i].e_pend});
    end

    // Blink with two frames per phase; frame 0 is the commit frame.
    blink_exp[0] = 12'h00F; blink_exp[1] = 12'h00F; blink_exp[2] = 12'hFFF;
    blink_exp[3] = 12'hFFF; blink_exp[4] = 12'h00F;
    step(1'b0, 1'b0, 1'b1, 12'h00F, 12'hFFF, 2'b01);
    for (int f = 0; f < 5; f++) begin
      frame();
      chk($sformatf("blink frame%0d rgb_out", f), rgb_out, blink_exp[f]);
    end

    // Second request while one is pending must be dropped.
    step(1'b0, 1'b0, 1'b1, 12'h456, 12'h000, 2'b00);
    chk("pend1 cfg_ready", {11'b0, cfg_ready}, 12'h000);
    step(1'b0, 1'b0, 1'b1, 12'h123, 12'h000, 2'b00);
    chk("pend2 pending", {11'b0, pending}, 12'h001);
    chk("pend2 cfg_ready", {11'b0, cfg_ready}, 12'h000);
    frame();
    chk("pend commit rgb_out", rgb_out, 12'h456);
    frame();
    chk("pend next frame rgb_out", rgb_out, 12'h456);

    // Reset while pending discards the shadow update.
    step(1'b0, 1'b0, 1'b1, 12'hABC, 12'h000, 2'b00);
    chk("rstpend pending", {11'b0, pending}, 12'h001);
    step(1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 2'b00);
    chk("rstpend pending", {11'b0, pending}, 12'h000);
    chk("rstpend cfg_ready", {11'b0, cfg_ready}, 12'h001);
    chk("rstpend rgb_out", rgb_out, R_RGB);
    frame();
    chk("rstpend frame1 rgb_out", rgb_out, R_RGB);
    frame();
    chk("rstpend frame2 rgb_out", rgb_out, R_RGB);

    // Randomized frames checked against the reference model every cycle.
    hi = 1'b0;
    for (int f = 0; f < 150; f++) begin
      for (int ph = 0; ph < 2; ph++) begin
        len = hi ? $urandom_range(3, 8) : $urandom_range(3, 16);
        for (int k = 0; k < len; k++) begin
          rv  = ($urandom_range(0, 399) == 0);
          vv  = hi;
          cvv = ($urandom_range(0, 5) == 0);
          rc  = 12'($urandom);
          ra  = 12'($urandom);
          rm  = 2'($urandom_range(0, 3));
          step(rv, vv, cvv, rc, ra, rm);
          chk("rand rgb_out", rgb_out, m_rgb);
          chk("rand frame_tick", {11'b0, frame_tick}, {11'b0, m_tick});
          chk("rand cfg_ready", {11'b0, cfg_ready}, {11'b0, ~m_pend});
          chk("rand pending", {11'b0, pending}, {11'b0, m_pend});
        end
        hi = ~hi;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
